// File: rtl/inst_sequencer.sv
// inst_sequencer: steps the attention core through one Q write, K write,
// K load, execute and output drain per start request, emitting the
// 17-bit core instruction word as a combinational decode of state/counters.
module inst_sequencer #(
  parameter int unsigned total_cycle = 8,
  parameter int unsigned col         = 8,
  parameter int unsigned idle_gap    = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        in_valid,
  input  logic        ofifo_valid,
  output logic [16:0] inst,
  output logic        in_ready,
  output logic        busy,
  output logic        done
);

  localparam int unsigned CW       = 4;
  localparam int unsigned KGAP_LEN = 3;
  localparam int unsigned GAP_MAX  = (idle_gap > KGAP_LEN - 1) ? idle_gap : KGAP_LEN - 1;
  localparam int unsigned GW       = $clog2(GAP_MAX + 1);

  localparam logic [CW-1:0] Q_LAST    = CW'(total_cycle - 1);
  localparam logic [CW-1:0] K_LAST    = CW'(col - 1);
  localparam logic [GW-1:0] KGAP_LAST = GW'(KGAP_LEN - 1);
  localparam logic [GW-1:0] WAIT_LAST = GW'(idle_gap);

  typedef enum logic [3:0] {
    S_IDLE  = 4'd0,
    S_QWR   = 4'd1,
    S_QGAP  = 4'd2,
    S_KWR   = 4'd3,
    S_KGAP  = 4'd4,
    S_LOAD  = 4'd5,
    S_LTAIL = 4'd6,
    S_WAIT  = 4'd7,
    S_EXEC  = 4'd8,
    S_XGAP  = 4'd9,
    S_DRAIN = 4'd10,
    S_DONE  = 4'd11
  } state_e;

  // Field layout of the core instruction word, MSB first.
  typedef struct packed {
    logic          ofifo_rd;
    logic [CW-1:0] qkmem_add;
    logic [CW-1:0] pmem_add;
    logic          execute;
    logic          load;
    logic          qmem_rd;
    logic          qmem_wr;
    logic          kmem_rd;
    logic          kmem_wr;
    logic          pmem_rd;
    logic          pmem_wr;
  } inst_t;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;   // beat / address / row counter
  logic [GW-1:0] sub_q, sub_d;   // settle-gap counter, also LOAD lead-in flag
  inst_t         inst_c;

  // State and counter registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      sub_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sub_q   <= sub_d;
    end
  end

  // Next-state logic and instruction/handshake decode.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    sub_d    = sub_q;
    inst_c   = '0;
    in_ready = 1'b0;
    busy     = (state_q != S_IDLE);
    done     = 1'b0;

    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        sub_d = '0;
        if (start) state_d = S_QWR;
      end

      S_QWR: begin
        in_ready = 1'b1;
        if (in_valid) begin
          inst_c.qmem_wr   = 1'b1;
          inst_c.qkmem_add = cnt_q;
          if (cnt_q == Q_LAST) begin
            cnt_d   = '0;
            state_d = S_QGAP;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end

      S_QGAP: begin
        cnt_d   = '0;
        state_d = S_KWR;
      end

      S_KWR: begin
        in_ready = 1'b1;
        if (in_valid) begin
          inst_c.kmem_wr   = 1'b1;
          inst_c.qkmem_add = cnt_q;
          if (cnt_q == K_LAST) begin
            cnt_d   = '0;
            state_d = S_KGAP;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end

      S_KGAP: begin
        if (sub_q == KGAP_LAST) begin
          sub_d   = '0;
          state_d = S_LOAD;
        end else begin
          sub_d = sub_q + GW'(1);
        end
      end

      // First LOAD cycle is a lead-in without kmem_rd; sub_q marks it done.
      S_LOAD: begin
        inst_c.load = 1'b1;
        if (sub_q == '0) begin
          sub_d = GW'(1);
        end else begin
          inst_c.kmem_rd   = 1'b1;
          inst_c.qkmem_add = cnt_q;
          if (cnt_q == K_LAST) begin
            cnt_d   = '0;
            sub_d   = '0;
            state_d = S_LTAIL;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end

      S_LTAIL: begin
        inst_c.load = 1'b1;
        state_d     = S_WAIT;
      end

      S_WAIT: begin
        if (sub_q == WAIT_LAST) begin
          sub_d   = '0;
          state_d = S_EXEC;
        end else begin
          sub_d = sub_q + GW'(1);
        end
      end

      S_EXEC: begin
        inst_c.execute   = 1'b1;
        inst_c.qmem_rd   = 1'b1;
        inst_c.qkmem_add = cnt_q;
        if (cnt_q == Q_LAST) begin
          cnt_d   = '0;
          state_d = S_XGAP;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      S_XGAP: begin
        cnt_d   = '0;
        state_d = S_DRAIN;
      end

      S_DRAIN: begin
        if (ofifo_valid) begin
          inst_c.ofifo_rd = 1'b1;
          inst_c.pmem_wr  = 1'b1;
          inst_c.pmem_add = cnt_q;
          if (cnt_q == Q_LAST) begin
            cnt_d   = '0;
            state_d = S_DONE;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end

      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end

      default: begin
        cnt_d   = '0;
        sub_d   = '0;
        state_d = S_IDLE;
      end
    endcase

    // Reset silences every output in the same cycle it is asserted.
    if (reset) begin
      inst_c   = '0;
      in_ready = 1'b0;
      busy     = 1'b0;
      done     = 1'b0;
    end
  end

  assign inst = inst_c;

endmodule

// File: tb/tb_inst_sequencer.sv
// Scoreboard bench for inst_sequencer: every expected non-zero instruction
// word and done pulse is queued when a run is launched and popped by a
// negedge monitor as the DUT emits it.
module tb_inst_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        in_valid;
  logic        ofifo_valid;
  logic [16:0] inst;
  logic        in_ready;
  logic        busy;
  logic        done;

  inst_sequencer #(.total_cycle(8), .col(8), .idle_gap(10)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .in_valid    (in_valid),
    .ofifo_valid (ofifo_valid),
    .inst        (inst),
    .in_ready    (in_ready),
    .busy        (busy),
    .done        (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [16:0] inst;
    logic        done;
    int          cyc;   // cycle after the start edge, -1 when untimed
  } ev_t;

  ev_t sb[$];
  int  n_tests = 0;
  int  n_fail  = 0;
  int  rel     = 0;
  int  idle_cnt = 0;
  int  idle_before = 0;
  int  n_runs  = 0;
  bit  prev_busy = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [16:0] mk(input bit ofrd, input int qk, input int pa,
                                     input bit ex, input bit ld, input bit qrd,
                                     input bit qwr, input bit krd, input bit kwr,
                                     input bit pwr);
    logic [3:0] qk4;
    logic [3:0] pa4;
    qk4 = 4'(qk);
    pa4 = 4'(pa);
    return {ofrd, qk4, pa4, ex, ld, qrd, qwr, krd, kwr, 1'b0, pwr};
  endfunction

  function automatic void push(input logic [16:0] i, input logic d, input int c);
    ev_t e;
    e.inst = i;
    e.done = d;
    e.cyc  = c;
    sb.push_back(e);
  endfunction

  // Expected event stream of one run with default parameters.
  function automatic void push_run(input bit timed, input int done_cyc);
    for (int i = 0; i < 8; i++) push(mk(0, i, 0, 0, 0, 0, 1, 0, 0, 0), 1'b0, timed ? 1 + i : -1);
    for (int i = 0; i < 8; i++) push(mk(0, i, 0, 0, 0, 0, 0, 0, 1, 0), 1'b0, timed ? 10 + i : -1);
    push(mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 0), 1'b0, timed ? 21 : -1);
    for (int i = 0; i < 8; i++) push(mk(0, i, 0, 0, 1, 0, 0, 1, 0, 0), 1'b0, timed ? 22 + i : -1);
    push(mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 0), 1'b0, timed ? 30 : -1);
    for (int i = 0; i < 8; i++) push(mk(0, i, 0, 1, 0, 1, 0, 0, 0, 0), 1'b0, timed ? 42 + i : -1);
    for (int i = 0; i < 8; i++) push(mk(1, 0, i, 0, 0, 0, 0, 0, 0, 1), 1'b0, timed ? 51 + i : -1);
    push(17'd0, 1'b1, done_cyc);
  endfunction

  // Monitor: track run-relative cycle and pop/compare every emitted event.
  always @(negedge clk) begin
    ev_t e;
    if (reset) begin
      rel       = 0;
      idle_cnt  = 0;
      prev_busy = 1'b0;
    end else begin
      if (busy) begin
        if (!prev_busy) begin
          n_runs++;
          idle_before = idle_cnt;
        end
        rel++;
        idle_cnt = 0;
      end else begin
        rel = 0;
        idle_cnt++;
      end
      prev_busy = busy;
      if (inst != 17'd0 || done) begin
        if (sb.size() == 0) begin
          check_eq("unexpected_event", {14'd0, done, inst}, 32'd0);
        end else begin
          e = sb.pop_front();
          check_eq("inst", 32'(inst), 32'(e.inst));
          check_eq("done", 32'(done), 32'(e.done));
          if (e.cyc >= 0) check_eq("event_cycle", 32'(rel), 32'(e.cyc));
          if (inst[4] || inst[2]) check_eq("in_ready_on_write", 32'(in_ready), 32'd1);
        end
      end
    end
  end

  // Launch one run and drive in_valid/ofifo_valid each cycle until drained.
  task automatic do_run(input bit stall_q, input bit tog_o, input bit timed, input int done_cyc);
    int k;
    push_run(timed, done_cyc);
    @(posedge clk); #1;
    start = 1'b1; in_valid = 1'b1; ofifo_valid = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    k = 1;
    while (sb.size() > 0 && k < 200) begin
      in_valid    = stall_q ? !(k == 3 || k == 6) : 1'b1;
      ofifo_valid = tog_o ? (k % 2 == 1) : 1'b1;
      if (stall_q && k == 3) begin
        #1;
        check_eq("stall_in_ready", 32'(in_ready), 32'd1);
        check_eq("stall_inst", 32'(inst), 32'd0);
      end
      @(posedge clk); #1;
      k++;
    end
    check_eq("run_timeout", 32'(k < 200), 32'd1);
    check_eq("idle_after_done", 32'(busy), 32'd0);
    in_valid = 1'b1; ofifo_valid = 1'b1;
  endtask

  initial begin
    int k;
    int runs0;
    reset = 1'b1; start = 1'b0; in_valid = 1'b0; ofifo_valid = 1'b0;

    // Reset state, including start held during reset.
    repeat (3) @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk); #1;
    check_eq("rst_inst", 32'(inst), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_in_ready", 32'(in_ready), 32'd0);
    check_eq("rst_done", 32'(done), 32'd0);
    start = 1'b0;
    reset = 1'b0;
    @(posedge clk); #1;
    check_eq("idle_busy", 32'(busy), 32'd0);
    check_eq("idle_inst", 32'(inst), 32'd0);
    check_eq("idle_in_ready", 32'(in_ready), 32'd0);

    // Full-rate run: done in cycle 59.
    do_run(1'b0, 1'b0, 1'b1, 59);
    // Two Q-write stalls delay completion by two cycles.
    do_run(1'b1, 1'b0, 1'b0, 61);
    // Drain with ofifo_valid toggling 1,0,1,0...
    do_run(1'b0, 1'b1, 1'b0, 66);

    // Reset in the middle of EXEC at address 3.
    push_run(1'b0, -1);
    @(posedge clk); #1;
    start = 1'b1; in_valid = 1'b1; ofifo_valid = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    k = 0;
    while (!(inst[7] && inst[15:12] == 4'd3) && k < 200) begin
      @(posedge clk); #1;
      k++;
    end
    check_eq("exec3_reached", 32'(k < 200), 32'd1);
    reset = 1'b1;
    #1;
    check_eq("rst_exec_inst", 32'(inst), 32'd0);
    check_eq("rst_exec_busy", 32'(busy), 32'd0);
    check_eq("rst_exec_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    sb.delete();
    #1;
    check_eq("post_rst_busy", 32'(busy), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    check_eq("no_resume_busy", 32'(busy), 32'd0);
    check_eq("no_resume_inst", 32'(inst), 32'd0);
    do_run(1'b0, 1'b0, 1'b1, 59);

    // start held high through DONE: one IDLE cycle, then a fresh run.
    push_run(1'b1, 59);
    push_run(1'b1, 59);
    runs0 = n_runs;
    @(posedge clk); #1;
    start = 1'b1; in_valid = 1'b1; ofifo_valid = 1'b1;
    k = 0;
    while (sb.size() > 0 && k < 400) begin
      if (n_runs >= runs0 + 2) start = 1'b0;
      @(posedge clk); #1;
      k++;
    end
    start = 1'b0;
    check_eq("hold_timeout", 32'(k < 400), 32'd1);
    check_eq("hold_run_count", 32'(n_runs - runs0), 32'd2);
    check_eq("hold_idle_gap", 32'(idle_before), 32'd1);
    @(posedge clk); #1;
    check_eq("hold_final_idle", 32'(busy), 32'd0);
    check_eq("sb_empty", 32'(sb.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
